// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding, default width and counter sizing for shift_add_mult
package mult_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must hold the value W itself, hence W+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/add_rc.sv
// rtl/add_rc.sv - W-bit ripple-carry adder used as the single add stage of shift_add_mult
module add_rc #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]     = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co = c[W];

endmodule

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential shift-add unsigned multiplier; MULT_ZERO_BYPASS_EN enables zero-operand fast path
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   md;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mq;
    logic [CW-1:0]      cnt;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cy;
    logic               zero_hit;

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_hit = (a == '0) || (b == '0);
`else
    assign zero_hit = 1'b0;
`endif

    // A zero addend leaves acc unchanged and forces the carry to 0.
    assign addend = mq[0] ? md : '0;

    add_rc #(
        .W (WIDTH)
    ) u_add (
        .x  (acc),
        .y  (addend),
        .ci (1'b0),
        .s  (sum),
        .co (cy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = zero_hit ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md        <= '0;
            acc       <= '0;
            mq        <= '0;
            cnt       <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        md  <= a;
                        // Bypass lands in DONE directly, so {acc,mq} must already read zero.
                        mq  <= zero_hit ? '0 : b;
                        acc <= '0;
                        cnt <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    // Carry out of the add becomes the new acc MSB after the shift.
                    acc <= {cy, sum[WIDTH-1:1]};
                    mq  <= {sum[0], mq[WIDTH-1:1]};
                    cnt <= cnt - CW'(1);
                end
                DONE: begin
                    product_q <= {acc, mq};
                    done_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - directed table-driven self-checking bench for shift_add_mult
module tb_shift_add_mult;

    localparam int W     = 8;
    localparam int BOUND = 40;
`ifdef MULT_ZERO_BYPASS_EN
    localparam int ZLAT  = 1;
    localparam int ZBUSY = 0;
`else
    localparam int ZLAT  = W + 1;
    localparam int ZBUSY = W;
`endif

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks;
    int errors;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        int             lat;
        int             bz;
    } vec_t;

    vec_t vecs[10];

    shift_add_mult #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Counts edges from the accepting edge until done is seen, and busy cycles on the way.
    task automatic wait_done(output int lat, output int bz);
        lat = 0;
        bz  = 0;
        while (lat < BOUND) begin
            if (busy) bz++;
            if (done) break;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output int bz);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        wait_done(lat, bz);
    endtask

    initial begin
        int lat;
        int bz;
        int t;
        int d1;
        int d2;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;

        vecs[0] = '{8'd11,  8'd4,   16'd44,    W + 1, W};
        vecs[1] = '{8'd255, 8'd255, 16'd65025, W + 1, W};
        vecs[2] = '{8'd0,   8'd200, 16'd0,     ZLAT,  ZBUSY};
        vecs[3] = '{8'd1,   8'd1,   16'd1,     W + 1, W};
        vecs[4] = '{8'd255, 8'd1,   16'd255,   W + 1, W};
        vecs[5] = '{8'd128, 8'd2,   16'd256,   W + 1, W};
        vecs[6] = '{8'd13,  8'd17,  16'd221,   W + 1, W};
        vecs[7] = '{8'd200, 8'd0,   16'd0,     ZLAT,  ZBUSY};
        vecs[8] = '{8'd1,   8'd255, 16'd255,   W + 1, W};
        vecs[9] = '{8'd170, 8'd85,  16'd14450, W + 1, W};

        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_product", int'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, bz);
            chk($sformatf("v%0d_product", i), int'(product), int'(vecs[i].p));
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy", i), bz, vecs[i].bz);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), int'(done), 0);
            chk($sformatf("v%0d_hold", i), int'(product), int'(vecs[i].p));
        end

        // Second start during RUN must be ignored.
        @(negedge clk);
        a     = 8'd3;
        b     = 8'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        a     = 8'd7;
        b     = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bz);
        chk("ign_product", int'(product), 15);
        chk("ign_latency", lat + 3, W + 1);
        run_op(8'd7, 8'd7, lat, bz);
        chk("after_ign_product", int'(product), 49);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        a     = 8'd200;
        b     = 8'd100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_product", int'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_idle", int'(busy), 0);
        run_op(8'd200, 8'd100, lat, bz);
        chk("post_abort_product", int'(product), 20000);
        chk("post_abort_latency", lat, W + 1);

        // start held high: back-to-back operations.
        @(negedge clk);
        a     = 8'd2;
        b     = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        a  = 8'd4;
        b  = 8'd5;
        t  = 0;
        d1 = -1;
        d2 = -1;
        while (t < 3 * BOUND && d2 < 0) begin
            @(posedge clk);
            #1;
            t++;
            if (done) begin
                if (d1 < 0) begin
                    d1 = t;
                    chk("b2b_product1", int'(product), 6);
                end else begin
                    d2 = t;
                    start = 1'b0;
                    chk("b2b_product2", int'(product), 20);
                end
            end
        end
        start = 1'b0;
        chk("b2b_first_latency", d1, W + 1);
        chk("b2b_gap", d2 - d1, W + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
